// File: rtl/adc_word_framer_if.sv
// Output stream of the ADC word framer: one parallel sample word per
// valid/ready handshake toward the sample-processing pipeline.
interface adc_word_framer_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/adc_word_framer.sv
// ADC word framer: deserialises one LVDS lane on dco_clk, uses fco rising
// edges (gated by the alignment monitor) as word boundaries, and queues
// completed words in a small FIFO. Counts mis-sized frames and words lost
// to a full FIFO.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_ALIGN | monitor not locked; nothing is pushed
// WAIT_EDGE  | locked; next fco edge only re-syncs the bit counter
// RUN        | framing; good frames pushed, bad frames counted
module adc_word_framer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    parameter int CNT_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 dco_clk,
    input  logic                 rst_n,
    input  logic                 data_in,
    input  logic                 fco_in,
    input  logic                 aligned_in,
    adc_word_framer_if.master    m_bus,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 frame_err_pulse,
    output logic [CNT_W-1:0]     frame_err_count,
    output logic [CNT_W-1:0]     drop_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BCNT_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        WAIT_ALIGN = 2'd0,
        WAIT_EDGE  = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                fco_d;
    logic                fco_edge;
    logic [WORD_W-1:0]   sr;
    logic [WORD_W-1:0]   sr_next;
    logic [BCNT_W-1:0]   bit_cnt;
    logic                frame_good;
    logic                push_req;
    logic                flush;
    logic                frame_err;

    logic [WORD_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [LVL_W-1:0]    count;
    logic                pop;
    logic                full;
    logic                do_push;
    logic                drop;

    assign fco_edge   = fco_in & ~fco_d;
    assign frame_good = (bit_cnt == BCNT_W'(WORD_W - 1));

    // The candidate word already includes the bit sampled in the edge cycle.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign sr_next = {sr[WORD_W-2:0], data_in};
        end else begin : g_lsb_first
            assign sr_next = {data_in, sr[WORD_W-1:1]};
        end
    endgenerate

    // Front end: fco edge history, deserialiser, bits-since-edge counter.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            fco_d   <= 1'b0;
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            fco_d <= fco_in;
            sr    <= sr_next;
            if (fco_edge) begin
                bit_cnt <= '0;
            end else if (bit_cnt != BCNT_W'(WORD_W)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_ALIGN;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and per-edge decisions; losing alignment beats any edge.
    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        flush      = 1'b0;
        frame_err  = 1'b0;
        case (state)
            WAIT_ALIGN: begin
                if (aligned_in) begin
                    state_next = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (!aligned_in) begin
                    state_next = WAIT_ALIGN;
                end else if (fco_edge) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!aligned_in) begin
                    state_next = WAIT_ALIGN;
                    flush      = 1'b1;
                end else if (fco_edge) begin
                    if (frame_good) begin
                        push_req = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
            default: begin
                state_next = WAIT_ALIGN;
            end
        endcase
    end

    assign m_bus.m_valid = (count != '0);
    assign m_bus.m_data  = mem[rd_ptr];
    assign fifo_level    = count;
    assign pop           = m_bus.m_valid && m_bus.m_ready;
    assign full          = (count == LVL_W'(FIFO_DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push       = push_req && (!full || pop);
    assign drop          = push_req && full && !pop;

    // Output FIFO; a flush empties it regardless of a concurrent pop.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= sr_next;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !pop) begin
                count <= count + 1'b1;
            end else if (!do_push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Error pulse and saturating event counters.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_pulse <= 1'b0;
            frame_err_count <= '0;
            drop_count      <= '0;
        end else begin
            frame_err_pulse <= frame_err;
            if (frame_err && (frame_err_count != '1)) begin
                frame_err_count <= frame_err_count + 1'b1;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/adc_word_framer.md
Name: adc_word_framer

Overview:
Downstream neighbour of fco_align_monitor in the ADC LVDS frontend. Runs on the DCO clock and shifts one serial data bit per cycle. Uses fco_in rising edges as word boundaries, gated by the monitor's `aligned` flag, to assemble parallel sample words. Completed words go through a small FIFO with a valid/ready handshake to the sample-processing pipeline, and the block counts dropped and mis-framed words.

Parameters:
WORD_W, 8, bits per ADC word; equals the monitor's EXPECT_PERIOD.
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
MSB_FIRST, 1, 1 = first serial bit is the word MSB; 0 = LSB first.
CNT_W, 16, width of the saturating drop and frame-error counters.

Ports:
dco_clk  in  1  sole clock, all logic on its posedge.
rst_n  in  1  asynchronous active-low reset.
data_in  in  1  serial ADC lane bit, one per dco_clk.
fco_in  in  1  frame clock; a rising edge marks the last bit of a word.
aligned_in  in  1  from fco_align_monitor.aligned.
m_data  out  WORD_W  head-of-FIFO word.
m_valid  out  1  FIFO non-empty.
m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
fifo_level  out  $clog2(FIFO_DEPTH+1)  current occupancy.
frame_err_pulse  out  1  one-cycle pulse on a mis-sized frame.
frame_err_count  out  CNT_W  saturating count of frame errors.
drop_count  out  CNT_W  saturating count of words lost to a full FIFO.

Behaviour:
- Reset (async assert, sync release) clears everything:
  - Outputs: m_valid=0, m_data=0, fifo_level=0, frame_err_pulse=0, frame_err_count=0, drop_count=0.
  - Internal: FSM=WAIT_ALIGN, shift reg=0, fco_d=0, bit_cnt=0.
- Edge detect: `edge = fco_in & ~fco_d`, with fco_d registered every cycle.
- Shift register, every cycle:
  - MSB_FIRST=1: `sr <= {sr[W-2:0], data_in}`.
  - MSB_FIRST=0: `sr <= {data_in, sr[W-1:1]}`.
  - The candidate word is the next value of sr, so the bit sampled in the edge cycle is the last bit of the word.
- bit_cnt:
  - Counts non-edge cycles since the last edge and saturates at WORD_W.
  - Cleared to 0 in an edge cycle.
  - A frame is good iff bit_cnt == WORD_W-1 at the edge.
- FSM:
  - WAIT_ALIGN: no pushes. Go to WAIT_EDGE when aligned_in=1.
  - WAIT_EDGE: the first edge re-syncs bit_cnt, pushes nothing and raises no error; then go to RUN. If aligned_in=0, go to WAIT_ALIGN.
  - RUN, on each edge:
    - Good frame: push the candidate word.
    - Bad frame: no push; frame_err_pulse=1 next cycle; frame_err_count+1, saturating at all-ones.
  - RUN, on aligned_in=0: go to WAIT_ALIGN and flush the FIFO on that clock. Any push in the same cycle is discarded.
  - If an edge and aligned_in falling coincide, the flush wins: no push and no frame error.
- FIFO:
  - Registered head; m_data is valid only while m_valid=1.
  - Push-to-visible latency: edge cycle N gives m_valid=1 at N+1 when the FIFO was empty.
  - Pop when m_valid && m_ready.
  - Push and pop in the same cycle: occupancy unchanged. This is allowed when full, so no drop occurs.
  - Push when full without a pop: word discarded; drop_count+1, saturating.
  - Pop on empty: ignored.
  - Flush cycle: a pop in that cycle still completes; then level=0 and m_valid=0 on the next cycle.
- m_data holds its value while m_valid && !m_ready. Data ordering is strictly FIFO.
- Counters are cleared only by reset.

Test Plan:
- Lock and stream:
  - Stimulus: rst 2 cycles; aligned_in=1; fco edge every 8 cycles; serial MSB-first words 0xA5, 0x3C, 0x0F; m_ready=1.
  - Required: the first edge is discarded; then m_data sequence 0xA5, 0x3C, 0x0F, each valid 1 cycle after its edge; frame_err_count=0.
- LSB-first:
  - Stimulus: MSB_FIRST=0, bits 1,0,0,0,0,0,0,0.
  - Required: m_data=0x01.
- Backpressure:
  - Stimulus: m_ready=0 for 6 good frames.
  - Required: fifo_level=4, drop_count=2, m_data holds the first word.
  - Then raise m_ready: the 4 words drain in order.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, m_ready=1 in an edge cycle.
  - Required: level stays 4, drop_count unchanged.
- Bad frame:
  - Stimulus: in RUN, an edge after 6 cycles.
  - Required: frame_err_pulse one cycle, frame_err_count=1, no push; the next 8-cycle frame is pushed normally.
- Alignment loss and reset mid-stream:
  - Stimulus: drop aligned_in with 3 words queued.
  - Required: fifo_level=0 and m_valid=0 next cycle; no pushes until aligned_in=1 plus one resync edge.
  - Then assert rst_n=0 asynchronously mid-frame: all outputs are 0 immediately.
